spike_output_buffer: RTL

SPIKE_OUTPUT_BUFFER -- requirements
Module: spike_output_buffer

---
 rtl/spike_output_buffer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/spike_output_buffer.sv
// rtl/spike_output_buffer.sv - timestamped spike FIFO with byte-serial readout
// Captures output spike vectors on result-valid edges and streams {stamp, spikes} byte pairs.
module spike_output_buffer #(
    parameter int DEPTH   = 8,
    parameter int NEURONS = 8
) (
    input  logic                      system_clock,
    input  logic                      rst_n,
    input  logic [NEURONS-1:0]        output_spikes,
    input  logic                      output_data_ready,
    input  logic                      clear,
    input  logic                      out_ready,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    output logic                      out_is_stamp,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      fifo_empty,
    output logic                      fifo_full,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 8 + NEURONS;

    typedef enum logic [1:0] {
        IDLE,
        SEND_STAMP,
        SEND_SPIKES
    } state_t;

    state_t         state;
    state_t         state_next;

    logic           ready_q;
    logic [7:0]     timestep;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic [EW-1:0]  mem [DEPTH];
    logic [EW-1:0]  head;
    logic [7:0]     spike_byte;

    logic           capture;
    logic           pop;
    logic           push;
    logic           flush;

    assign flush      = clear;
    assign capture    = output_data_ready & ~ready_q;
    assign pop        = (state == SEND_SPIKES) && out_ready;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign push       = capture && (!fifo_full || pop);

    assign fifo_count = count;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign head       = mem[rd_ptr];

    generate
        if (NEURONS >= 8) begin : g_spike_trunc
            assign spike_byte = head[7:0];
        end else begin : g_spike_pad
            assign spike_byte = {{(8 - NEURONS){1'b0}}, head[NEURONS-1:0]};
        end
    endgenerate

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // The edge register keeps tracking through a flush so a held-high ready is not re-captured.
    always_ff @(posedge system_clock) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= output_data_ready;
        end
    end

    always_ff @(posedge system_clock) begin
        if (!rst_n || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            timestep <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            if (capture) begin
                timestep <= timestep + 8'd1;
            end
            if (capture && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge system_clock) begin
        if (rst_n && !flush && push) begin
            mem[wr_ptr] <= {timestep, output_spikes};
        end
    end

    always_ff @(posedge system_clock) begin
        if (!rst_n || flush) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs depend only on state and the head entry, so they hold steady under back-pressure.
    always_comb begin
        state_next   = state;
        out_valid    = 1'b0;
        out_is_stamp = 1'b0;
        out_data     = 8'h00;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = SEND_STAMP;
                end
            end
            SEND_STAMP: begin
                out_valid    = 1'b1;
                out_is_stamp = 1'b1;
                out_data     = head[EW-1:NEURONS];
                if (out_ready) begin
                    state_next = SEND_SPIKES;
                end
            end
            SEND_SPIKES: begin
                out_valid = 1'b1;
                out_data  = spike_byte;
                if (out_ready) begin
                    state_next = (count_next != '0) ? SEND_STAMP : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
